// File: rtl/vTPU_pkg.sv
// Shared vTPU array geometry and the activation skew scheduler's state encoding.
package vTPU_pkg;

  localparam int MUL_DATAWIDTH = 8;
  localparam int M             = 1;
  localparam int BETA          = 1;
  localparam int X_SCALED      = 8;
  localparam int ROW_W         = MUL_DATAWIDTH * M * BETA;
  localparam int K_W           = 16;
  localparam int DRAIN_CYCLES  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/act_skew_window.sv
// Combinational diagonal window: row i is active while i <= c < i+k.
// Compares run one bit wider than c so i+k never wraps for the largest k.
module act_skew_window #(
  parameter int X_SCALED = 8,
  parameter int K_W      = 16
) (
  input  logic [K_W:0]        c,
  input  logic [K_W-1:0]      k,
  output logic [X_SCALED-1:0] active
);

  always_comb begin
    active = '0;
    for (int i = 0; i < X_SCALED; i++) begin
      active[i] = ({1'b0, c} >= (K_W+2)'(i)) &&
                  ({1'b0, c} <  ((K_W+2)'(i) + {2'b00, k}));
    end
  end

endmodule

// File: rtl/act_skew_scheduler.sv
// Tile FSM streaming skewed activation rows into the systolic array: pops are
// combinational, array operands registered (pop at t -> operand at t+1), global stall keeps skew.
module act_skew_scheduler #(
  parameter int X_SCALED     = vTPU_pkg::X_SCALED,
  parameter int ROW_W        = vTPU_pkg::ROW_W,
  parameter int K_W          = vTPU_pkg::K_W,
  parameter int DRAIN_CYCLES = vTPU_pkg::DRAIN_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [K_W-1:0]            cfg_k_len,
  input  logic                      acc_ready,
  input  logic [X_SCALED*ROW_W-1:0] fifo_data,
  input  logic [X_SCALED-1:0]       fifo_empty,
  output logic [X_SCALED-1:0]       fifo_pop,
  output logic [X_SCALED*ROW_W-1:0] acc_in,
  output logic [X_SCALED-1:0]       acc_valid,
  output logic                      acc_step,
  output logic                      busy,
  output logic                      stall,
  output logic                      done
);
  import vTPU_pkg::*;

  sched_state_t              state_q, state_d;
  logic [K_W-1:0]            k_q, k_d;
  logic [K_W:0]              c_q, c_d;
  logic [K_W:0]              d_q, d_d;
  logic [X_SCALED*ROW_W-1:0] acc_in_q, acc_in_d;
  logic [X_SCALED-1:0]       acc_valid_q, acc_valid_d;
  logic                      acc_step_q, acc_step_d;

  logic [X_SCALED-1:0]       active;
  logic                      in_stream;
  logic                      advance;
  logic [K_W:0]              last_c;

  act_skew_window #(
    .X_SCALED (X_SCALED),
    .K_W      (K_W)
  ) u_window (
    .c      (c_q),
    .k      (k_q),
    .active (active)
  );

  // Final stream step index is k+X_SCALED-2; k>=1 whenever STREAM is entered.
  assign last_c    = {1'b0, k_q} + (K_W+1)'(X_SCALED - 2);
  assign in_stream = (state_q == STREAM);
  assign stall     = in_stream && (!acc_ready || |(active & fifo_empty));
  assign advance   = in_stream && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      acc_in_q    <= '0;
      acc_valid_q <= '0;
      acc_step_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      c_q         <= c_d;
      d_q         <= d_d;
      acc_in_q    <= acc_in_d;
      acc_valid_q <= acc_valid_d;
      acc_step_q  <= acc_step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    d_d     = d_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = cfg_k_len;
          c_d     = '0;
          state_d = (cfg_k_len != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (advance) begin
          c_d = c_q + 1'b1;
          if (c_q == last_c) begin
            state_d = FLUSH;
            d_d     = '0;
          end
        end
      end
      FLUSH: begin
        d_d = d_q + 1'b1;
        if (d_q == (K_W+1)'(DRAIN_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stalled cycles emit no step and keep the last operands on the row inputs.
  always_comb begin
    fifo_pop    = advance ? active : '0;
    acc_step_d  = advance;
    acc_valid_d = advance ? active : '0;
    acc_in_d    = acc_in_q;
    if (advance) begin
      for (int i = 0; i < X_SCALED; i++) begin
        acc_in_d[i*ROW_W +: ROW_W] = active[i] ? fifo_data[i*ROW_W +: ROW_W] : '0;
      end
    end
  end

  assign acc_in    = acc_in_q;
  assign acc_valid = acc_valid_q;
  assign acc_step  = acc_step_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_act_skew_scheduler.sv
// Directed bench for act_skew_scheduler with a 4-row array and a counting FIFO model
// whose words encode {row, word index}, so data order is visible on acc_in.
module tb_act_skew_scheduler;

  localparam int X  = 4;
  localparam int RW = 8;
  localparam int KW = 16;
  localparam int DR = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [KW-1:0]     cfg_k_len;
  logic              acc_ready;
  logic [X*RW-1:0]   fifo_data;
  logic [X-1:0]      fifo_empty;
  logic [X-1:0]      fifo_pop;
  logic [X*RW-1:0]   acc_in;
  logic [X-1:0]      acc_valid;
  logic              acc_step;
  logic              busy;
  logic              stall;
  logic              done;

  always #5 clk = ~clk;

  act_skew_scheduler #(
    .X_SCALED     (X),
    .ROW_W        (RW),
    .K_W          (KW),
    .DRAIN_CYCLES (DR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_k_len  (cfg_k_len),
    .acc_ready  (acc_ready),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .acc_in     (acc_in),
    .acc_valid  (acc_valid),
    .acc_step   (acc_step),
    .busy       (busy),
    .stall      (stall),
    .done       (done)
  );

  int              cnt [X];
  int              n_cmp = 0;
  int              n_err = 0;
  logic [X-1:0]    pop_s;
  logic            stall_s;
  logic [X*RW-1:0] exp_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < X; i++) fifo_data[i*RW +: RW] = RW'(i*16 + cnt[i]);
  endtask

  // Sample combinational outputs just before the edge, registered ones 1ns after it.
  task automatic tick();
    #1;
    pop_s   = fifo_pop;
    stall_s = stall;
    @(posedge clk);
    #1;
    for (int i = 0; i < X; i++) if (pop_s[i]) cnt[i]++;
    drive_data();
  endtask

  function automatic logic [X-1:0] act_exp(input int c, input int k);
    logic [X-1:0] a;
    a = '0;
    for (int i = 0; i < X; i++) a[i] = (c >= i) && (c < i + k);
    return a;
  endfunction

  // skind: 0 none, 1 row-2 empty, 2 acc_ready low, 3 inactive rows empty (no stall)
  task automatic run_tile(input int k, input int skind, input int sat, input int slen, input bit ign);
    int c, st, pops, tmo;
    bit es;
    logic [X-1:0] a;
    c = 0; st = 0; pops = 0; tmo = 0;
    for (int i = 0; i < X; i++) cnt[i] = 0;
    drive_data();
    acc_ready  = 1'b1;
    fifo_empty = '0;
    start      = 1'b1;
    cfg_k_len  = KW'(k);
    tick();
    start     = 1'b0;
    cfg_k_len = '0;
    chk("busy_after_start", busy, 1);
    while (c < k + X - 1 && tmo < 500) begin
      es = 1'b0;
      acc_ready  = 1'b1;
      fifo_empty = '0;
      a = act_exp(c, k);
      if (skind == 1 && c == sat && st < slen) begin fifo_empty = 4'b0100; es = 1'b1; st++; end
      if (skind == 2 && c == sat && st < slen) begin acc_ready = 1'b0; es = 1'b1; st++; end
      if (skind == 3 && c == sat) fifo_empty = ~a;
      start     = (ign && c == 2);
      cfg_k_len = (ign && c == 2) ? KW'(9) : '0;
      tick();
      chk("stall", stall_s, es);
      chk("pop", pop_s, es ? '0 : a);
      chk("acc_step", acc_step, !es);
      chk("acc_valid", acc_valid, es ? '0 : a);
      pops += $countones(pop_s);
      if (!es) begin
        for (int i = 0; i < X; i++) exp_in[i*RW +: RW] = a[i] ? RW'(i*16 + c - i) : '0;
        c++;
      end
      chk("acc_in", acc_in, exp_in);
      tmo++;
    end
    chk("stream_timeout", tmo < 500, 1);
    start      = 1'b0;
    cfg_k_len  = '0;
    acc_ready  = 1'b0;
    fifo_empty = '1;
    for (int j = 1; j <= DR + 1; j++) begin
      start = (ign && j == 5);
      tick();
      chk("flush_pop", pop_s, 0);
      chk("flush_stall", stall_s, 0);
      chk("flush_step", acc_step, 0);
      chk("flush_valid", acc_valid, 0);
      chk("flush_acc_in", acc_in, exp_in);
      chk("done", done, (j == DR));
      chk("busy", busy, (j <= DR));
    end
    start = 1'b0;
    chk("pop_total", pops, k * X);
    for (int i = 0; i < X; i++) chk("row_pops", cnt[i], k);
    acc_ready  = 1'b1;
    fifo_empty = '0;
  endtask

  initial begin
    for (int i = 0; i < X; i++) cnt[i] = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    cfg_k_len  = '0;
    acc_ready  = 1'b1;
    fifo_empty = '0;
    exp_in     = '0;
    drive_data();
    tick();
    tick();
    chk("rst_acc_in", acc_in, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_acc_step", acc_step, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1'b1;
    tick();

    // Nominal skew, hand-written pop pattern for k=3 first.
    begin
      logic [X-1:0] nom [6];
      nom = '{4'h1, 4'h3, 4'h7, 4'he, 4'hc, 4'h8};
      for (int c = 0; c < 6; c++) chk("nom_table", act_exp(c, 3), nom[c]);
    end
    run_tile(3, 0, 0, 0, 1'b0);
    run_tile(3, 1, 3, 2, 1'b0);
    run_tile(3, 2, 2, 3, 1'b0);
    run_tile(3, 3, 1, 0, 1'b0);
    run_tile(1, 0, 0, 0, 1'b0);

    // Zero-length tile.
    start     = 1'b1;
    cfg_k_len = '0;
    tick();
    start = 1'b0;
    chk("zero_pop0", pop_s, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_step", acc_step, 0);
    tick();
    chk("zero_pop1", pop_s, 0);
    chk("zero_done_end", done, 0);
    chk("zero_busy_end", busy, 0);

    // Reset two steps into a tile.
    for (int i = 0; i < X; i++) cnt[i] = 0;
    drive_data();
    start     = 1'b1;
    cfg_k_len = KW'(3);
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_step", acc_step, 1);
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    exp_in = '0;
    chk("mid_rst_valid", acc_valid, 0);
    chk("mid_rst_step", acc_step, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_acc_in", acc_in, 0);
    #1;
    chk("mid_rst_pop", fifo_pop, 0);
    chk("mid_rst_stall", stall, 0);
    run_tile(3, 0, 0, 0, 1'b0);

    // Starts pulsed in STREAM and FLUSH are ignored.
    run_tile(3, 0, 0, 0, 1'b1);
    tick();
    chk("ign_idle_busy", busy, 0);
    chk("ign_idle_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
